// File: rtl/bcd_count_n.sv
// bcd_count_n: N-digit BCD up/down counter with clamped binary terminal value
// converted to BCD serially by shift-add-3 before counting starts.
module bcd_count_n #(
   parameter int DIGITS = 2,
   parameter int MAX_W  = 7
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  run,
   input  logic                  ce,
   input  logic                  dir,
   input  logic                  wrap,
   input  logic [MAX_W-1:0]      max_count,
   output logic [4*DIGITS-1:0]   digits,
   output logic                  busy,
   output logic                  done,
   output logic                  tc
);
   localparam int DW = 4*DIGITS;
   localparam int CW = $clog2(MAX_W+1);
   localparam logic [31:0] LIM = 32'(10**DIGITS - 1);
   typedef enum logic [1:0] {IDLE, CONVERT, COUNT, DONE} state_t;
   state_t r_state, w_next;
   logic [MAX_W-1:0] r_bin, w_clamped;
   logic [DW-1:0] r_bcd, r_max_bcd, w_adj, w_shift, w_inc, w_dec, w_start, w_term, w_digits;
   logic [CW-1:0] r_cnt;
   logic r_dir, r_wrap, w_last, w_at_term, w_tc;
   assign w_clamped = (32'(max_count) > LIM) ? MAX_W'(LIM) : max_count;
   assign w_last    = r_cnt == CW'(MAX_W-1);
   assign w_start   = r_dir ? '0 : '0;
   assign w_term    = r_dir ? '0 : r_max_bcd;
   assign w_at_term = digits == w_term;
   assign w_shift   = {w_adj[DW-2:0], r_bin[MAX_W-1]};
   always_comb begin : arith
      logic cu, cd;
      w_adj = '0;
      w_inc = '0;
      w_dec = '0;
      cu = 1'b1;
      cd = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         w_adj[4*i+:4] = (r_bcd[4*i+:4] >= 4'd5) ? r_bcd[4*i+:4] + 4'd3 : r_bcd[4*i+:4];
         w_inc[4*i+:4] = !cu ? digits[4*i+:4] : (digits[4*i+:4] == 4'd9) ? 4'd0 : digits[4*i+:4] + 4'd1;
         w_dec[4*i+:4] = !cd ? digits[4*i+:4] : (digits[4*i+:4] == 4'd0) ? 4'd9 : digits[4*i+:4] - 4'd1;
         cu = cu & (digits[4*i+:4] == 4'd9);
         cd = cd & (digits[4*i+:4] == 4'd0);
      end
   end
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) r_state <= IDLE;
      else        r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = run ? CONVERT : IDLE;
         CONVERT: w_next = !run ? IDLE : w_last ? COUNT : CONVERT;
         COUNT:   w_next = !run ? IDLE : (ce && w_at_term && !r_wrap) ? DONE : COUNT;
         default: w_next = run ? DONE : IDLE;
      endcase
   end
   // the start value on the last convert cycle comes straight from the final shift
   always_comb begin
      w_digits = '0;
      case (r_state)
         CONVERT: w_digits = (w_last && r_dir) ? w_shift : '0;
         COUNT:   w_digits = !ce ? digits : !w_at_term ? (r_dir ? w_dec : w_inc) : r_wrap ? (r_dir ? r_max_bcd : '0) : digits;
         DONE:    w_digits = digits;
         default: w_digits = '0;
      endcase
      if (!run) w_digits = '0;
      w_tc = run && (r_state == COUNT) && ce && w_at_term;
   end
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         digits    <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         tc        <= 1'b0;
         r_bin     <= '0;
         r_bcd     <= '0;
         r_max_bcd <= '0;
         r_cnt     <= '0;
         r_dir     <= 1'b0;
         r_wrap    <= 1'b0;
      end else begin
         digits <= w_digits;
         busy   <= (w_next == CONVERT) || (w_next == COUNT);
         done   <= w_next == DONE;
         tc     <= w_tc;
         if (r_state == IDLE) begin
            r_bin  <= w_clamped;
            r_dir  <= dir;
            r_wrap <= wrap;
            r_bcd  <= '0;
            r_cnt  <= '0;
         end else if (r_state == CONVERT) begin
            r_bin <= r_bin << 1;
            r_bcd <= w_shift;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) r_max_bcd <= w_shift;
         end
      end
endmodule

// File: tb/tb_bcd_count_n.sv
// tb_bcd_count_n: directed checks of the 2-digit BCD counter across conversion,
// up/down counting, wrap/stop terminals, ce gating and async reset.
module tb_bcd_count_n;
   logic       CLK = 1'b0, RST_N = 1'b0, run = 1'b0, ce = 1'b0, dir = 1'b0, wrap = 1'b0;
   logic [6:0] max_count = '0;
   logic [7:0] digits;
   logic       busy, done, tc;
   int n_vec = 0, n_err = 0;
   bcd_count_n #(.DIGITS(2), .MAX_W(7)) dut (
      .CLK(CLK), .RST_N(RST_N), .run(run), .ce(ce), .dir(dir), .wrap(wrap),
      .max_count(max_count), .digits(digits), .busy(busy), .done(done), .tc(tc)
   );
   always #5 CLK = ~CLK;
   function automatic logic [31:0] bcd(input int v);
      return {24'd0, 4'(v / 10), 4'(v % 10)};
   endfunction
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic idle_then_start(input logic [6:0] m, input logic d, input logic w, input logic c);
      run = 1'b0;
      tick();
      max_count = m; dir = d; wrap = w; ce = c; run = 1'b1;
      tick();
   endtask
   initial begin
      tick(); tick();
      chk("rst_digits", digits, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_tc", tc, 0);
      @(negedge CLK); RST_N = 1'b1;
      tick();
      // 1: up to 73, stop; max_count change mid-convert ignored
      idle_then_start(7'd73, 1'b0, 1'b0, 1'b1);
      chk("t1_busy_cap", busy, 1);
      for (int i = 1; i <= 7; i++) begin
         tick();
         if (i == 5) max_count = 7'd15;
         chk("t1_conv_zero", digits, 0);
      end
      chk("t1_busy_conv", busy, 1);
      for (int v = 1; v <= 73; v++) begin
         tick();
         chk("t1_up", digits, bcd(v));
      end
      chk("t1_tc_pre", tc, 0);
      tick();
      chk("t1_tc", tc, 1);
      chk("t1_done", done, 1);
      chk("t1_hold", digits, 32'h73);
      chk("t1_busy_done", busy, 0);
      tick();
      chk("t1_tc_clr", tc, 0);
      chk("t1_done_hold", done, 1);
      // 2: clamp 118 -> 99, then run=0 clears
      idle_then_start(7'd118, 1'b0, 1'b0, 1'b1);
      repeat (7) tick();
      for (int v = 1; v <= 99; v++) begin
         tick();
         chk("t2_up", digits, bcd(v));
      end
      tick();
      chk("t2_done", done, 1);
      chk("t2_hold", digits, 32'h99);
      run = 1'b0;
      tick();
      chk("t2_clr_dig", digits, 0);
      chk("t2_clr_done", done, 0);
      // 3: down from 15 with wrap; dir/wrap changes while running ignored
      idle_then_start(7'd15, 1'b1, 1'b1, 1'b1);
      for (int i = 1; i <= 7; i++) begin
         tick();
         chk("t3_conv", digits, (i == 7) ? 32'h15 : 32'h0);
      end
      dir = 1'b0; wrap = 1'b0; max_count = 7'd40;
      for (int p = 0; p < 2; p++) begin
         for (int v = 14; v >= 0; v--) begin
            tick();
            chk("t3_down", digits, bcd(v));
            chk("t3_tc_low", tc, 0);
         end
         tick();
         chk("t3_reload", digits, 32'h15);
         chk("t3_tc", tc, 1);
         chk("t3_done_low", done, 0);
      end
      // 4: ce every 4th cycle, up to 12
      idle_then_start(7'd12, 1'b0, 1'b0, 1'b0);
      repeat (7) tick();
      for (int v = 1; v <= 12; v++) begin
         ce = 1'b1;
         tick();
         chk("t4_step", digits, bcd(v));
         ce = 1'b0;
         repeat (3) tick();
         chk("t4_hold", digits, bcd(v));
      end
      chk("t4_done_pre", done, 0);
      ce = 1'b1;
      tick();
      chk("t4_tc", tc, 1);
      chk("t4_done", done, 1);
      chk("t4_final", digits, 32'h12);
      ce = 1'b0;
      tick();
      chk("t4_tc_clr", tc, 0);
      // 5: max 0, stop then wrap
      idle_then_start(7'd0, 1'b0, 1'b0, 1'b1);
      repeat (7) tick();
      chk("t5_start", digits, 0);
      tick();
      chk("t5s_tc", tc, 1);
      chk("t5s_done", done, 1);
      chk("t5s_dig", digits, 0);
      idle_then_start(7'd0, 1'b0, 1'b1, 1'b1);
      repeat (7) tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5w_tc", tc, 1);
         chk("t5w_dig", digits, 0);
         chk("t5w_done", done, 0);
      end
      ce = 1'b0;
      tick();
      chk("t5w_tc_off", tc, 0);
      // run=0 mid-convert
      idle_then_start(7'd50, 1'b0, 1'b0, 1'b1);
      repeat (3) tick();
      run = 1'b0;
      tick();
      chk("run0_busy", busy, 0);
      // 6: async reset in COUNT at 42, then mid-convert
      run = 1'b1;
      tick();
      repeat (7) tick();
      repeat (42) tick();
      chk("t6_at42", digits, 32'h42);
      #2 RST_N = 1'b0;
      #1;
      chk("t6_rst_dig", digits, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_done", done, 0);
      #3 RST_N = 1'b1;
      tick();
      chk("t6_restart_busy", busy, 1);
      repeat (3) tick();
      #2 RST_N = 1'b0;
      #1;
      chk("t6_conv_rst_busy", busy, 0);
      chk("t6_conv_rst_dig", digits, 0);
      #3 RST_N = 1'b1;
      tick();
      chk("t6_restart2_busy", busy, 1);
      repeat (7) tick();
      chk("t6_start", digits, 0);
      tick();
      chk("t6_first", digits, 32'h01);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/bcd_count_n.md
Name: bcd_count_n

Overview:
Parametrised N-digit BCD up/down counter, the successor to the fixed 2-digit 7-bit counter.
- Takes a binary terminal value and clamps it to 10^DIGITS-1.
- Converts that value to BCD serially (shift-add-3 over MAX_W cycles).
- Counts on a clock-enable tick in up or down direction, stopping or wrapping at the terminal.
- Digit outputs feed the seven-segment display path.

Parameters:
DIGITS, 2, number of BCD digits (1..4)
MAX_W, 7, width of binary max_count input (must satisfy 2^MAX_W > 10^DIGITS-1 for clamp to be reachable; 1..14)

Ports:
CLK  in  1  system clock, rising edge
RST_N  in  1  asynchronous active-low reset
run  in  1  1 = convert/count, 0 = clear and idle
ce  in  1  count-enable tick; count steps only on cycles with ce=1
dir  in  1  0 = count up (0 -> max), 1 = count down (max -> 0)
wrap  in  1  0 = stop at terminal, 1 = reload start value and continue
max_count  in  MAX_W  binary terminal value
digits  out  4*DIGITS  BCD count; digit 0 (ones) in [3:0]
busy  out  1  high during CONVERT and COUNT
done  out  1  high while in DONE (stop mode reached terminal)
tc  out  1  one-cycle terminal-count pulse

Behaviour:
- Reset (RST_N=0, async): state=IDLE; digits=0, busy=0, done=0, tc=0; internal max/shift registers cleared.
- States: IDLE, CONVERT, COUNT, DONE. All outputs are registered.
- IDLE:
  - digits=0, busy=0, done=0.
  - When run=1 is sampled at clock t, the block captures three things at edge t:
    - max_count, clamped: if max_count > 10^DIGITS-1, the value is forced to 10^DIGITS-1.
    - dir.
    - wrap.
  - Then -> CONVERT.
- CONVERT:
  - Serial double-dabble over exactly MAX_W cycles; the bit counter goes 0..MAX_W-1.
  - digits hold 0. busy=1.
  - On the final cycle, max_bcd is complete and digits load the start value: 0 if dir=0, max_bcd if dir=1. -> COUNT.
  - First valid count appears MAX_W+1 edges after run is sampled high.
- COUNT, on each edge with ce=1:
  - If digits != terminal (max_bcd for up, 0 for down): step by one in BCD.
    - Up: ones 9 -> 0 with carry into the next digit.
    - Down: ones 0 -> 9 with borrow.
  - If digits == terminal and wrap=0: -> DONE; tc=1 for one cycle; digits hold.
  - If digits == terminal and wrap=1: digits reload the start value; tc=1 for one cycle; stay in COUNT.
  - ce=0: hold; tc=0.
- DONE: done=1, busy=0, digits hold the terminal value. Exit only via run=0.
- run=0 in any state: the next edge returns to IDLE with digits=0 and done=busy=tc=0, including mid-CONVERT.
- max_count, dir and wrap changes while run=1 are ignored; they are re-sampled only on the next IDLE->CONVERT transition.
- max_bcd=0:
  - Start equals terminal.
  - First ce in COUNT gives tc=1.
  - Stop mode -> DONE with digits=0.
  - Wrap mode: digits stay 0 and tc pulses on every ce.
- Arithmetic: digits never hold a non-BCD nibble (A-F) in any state.

Test Plan:
1. DIGITS=2, dir=0, wrap=0, ce=1, max_count=73, run 0->1. At +5 cycles, change max_count=15.
   -> digits=00 for 7 conversion cycles, then 00,01..73, no hex nibbles, tc pulse at 73, done=1. The max_count change has no effect.
2. max_count=118, dir=0, wrap=0 -> clamp; counts 00..99, done=1 holding 99. Then run=0 -> digits=00, done=0 on the next edge.
3. dir=1, wrap=1, max_count=15, ce=1 -> sequence 15,14..00,15,14...; tc pulses exactly on each 00->15 reload (every 16 ce ticks); done stays 0.
4. ce asserted every 4th cycle, dir=0, max_count=12 -> digits advance only on ce cycles. Borrow/carry check: 09->10 on a ce edge. done asserts at 12.
5. max_count=0, both wrap settings -> digits stay 00. tc on the first ce; wrap=0 gives done=1, wrap=1 gives tc on every ce.
6. RST_N pulled low asynchronously (between edges) while digits=42 in COUNT, and again mid-CONVERT.
   -> digits=0, busy=0, done=0 immediately. After release with run=1, a fresh conversion starts on the first edge.
